// File: rtl/usbf_pa_pkg.sv
// Shared encodings for the USB transmit packet assembler: one-hot states, PIDs,
// and byte helpers for PID framing and the LSB-first bit ordering of the wire.
package usbf_pa_pkg;

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_TOKEN = 6'b000010;
  localparam logic [5:0] ST_DPID  = 6'b000100;
  localparam logic [5:0] ST_DATA  = 6'b001000;
  localparam logic [5:0] ST_CRC1  = 6'b010000;
  localparam logic [5:0] ST_CRC2  = 6'b100000;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;

  // Upper nibble carries the check field so the receiver can validate the PID.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/usbf_crc16.sv
// Combinational USB CRC16 (x^16+x^15+x^2+1) update for one byte; din[7] is the
// first bit on the wire. Zero latency, no flow control.
module usbf_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  din,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_out = crc_step(crc_in, din);

endmodule

// File: rtl/usbf_pa_gen.sv
// Transmit packet assembler: handshake and data packets (PID, payload, CRC16) onto UTMI.
// First byte one cycle after the request; every byte and flag holds until tx_ready.
module usbf_pa_gen
  import usbf_pa_pkg::*;
#(
  parameter int MAX_PKT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_valid_last,
  output logic             tx_first,
  input  logic             tx_ready,
  input  logic             send_token,
  input  logic [3:0]       token_pid,
  input  logic             send_data,
  input  logic [3:0]       data_pid,
  input  logic [CNT_W-1:0] data_len,
  input  logic             abort,
  input  logic [7:0]       tx_data_st,
  output logic             rd_next,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT);

  logic [5:0]       state, state_nxt;
  logic [3:0]       pid;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      crc, crc_nxt;
  logic [7:0]       din_rev;
  logic             take;
  logic             too_long;

  // An aborted cycle never counts as an accepted byte.
  assign take     = tx_ready & ~abort;
  assign too_long = data_len > MAX_LEN;
  assign busy     = state != ST_IDLE;
  assign din_rev  = bitrev8(tx_data_st);

  usbf_crc16 u_crc16 (
    .crc_in  (crc),
    .din     (din_rev),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_nxt     = state;
    tx_data       = 8'h00;
    tx_valid      = 1'b0;
    tx_valid_last = 1'b0;
    tx_first      = 1'b0;
    rd_next       = 1'b0;
    done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (send_token)     state_nxt = ST_TOKEN;
        else if (send_data) state_nxt = ST_DPID;
      end
      ST_TOKEN: begin
        tx_valid      = 1'b1;
        tx_first      = 1'b1;
        tx_valid_last = 1'b1;
        tx_data       = pid_byte(pid);
        if (take) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DPID: begin
        tx_valid = 1'b1;
        tx_first = 1'b1;
        tx_data  = pid_byte(pid);
        if (take) state_nxt = (cnt != '0) ? ST_DATA : ST_CRC1;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = tx_data_st;
        rd_next  = take;
        if (take && cnt == CNT_W'(1)) state_nxt = ST_CRC1;
      end
      // CRC goes out complemented, high-order register bit first on the wire.
      ST_CRC1: begin
        tx_valid = 1'b1;
        tx_data  = ~bitrev8(crc[15:8]);
        if (take) state_nxt = ST_CRC2;
      end
      ST_CRC2: begin
        tx_valid      = 1'b1;
        tx_valid_last = 1'b1;
        tx_data       = ~bitrev8(crc[7:0]);
        if (take) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pid     <= 4'h0;
      cnt     <= '0;
      crc     <= 16'hFFFF;
      len_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_err <= 1'b0;
      if (state == ST_IDLE) begin
        if (send_token) begin
          pid <= token_pid;
        end else if (send_data) begin
          pid     <= data_pid;
          cnt     <= too_long ? MAX_LEN : data_len;
          crc     <= 16'hFFFF;
          len_err <= too_long;
        end
      end else if (state == ST_DATA && take) begin
        crc <= crc_nxt;
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usbf_pa_gen.sv
// Directed bench for usbf_pa_gen: handshake, zero-length, stalled, oversize, aborted, reset-interrupted packets.
// Latency: checks first byte one cycle after request and done in the final tx_ready cycle.
// Backpressure: drives tx_ready constant or toggling and verifies bytes and flags hold while stalled.
module tb_usbf_pa_gen;

    localparam int MAX_PKT = 1024;
    localparam int CNT_W   = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_valid, tx_valid_last, tx_first;
    logic             tx_ready = 1'b0;
    logic             send_token = 1'b0;
    logic [3:0]       token_pid = 4'h0;
    logic             send_data = 1'b0;
    logic [3:0]       data_pid = 4'h0;
    logic [CNT_W-1:0] data_len = '0;
    logic             abort = 1'b0;
    logic [7:0]       tx_data_st = 8'h00;
    logic             rd_next, busy, done, len_err;

    always #5 clk = ~clk;

    usbf_pa_gen #(.MAX_PKT(MAX_PKT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_valid_last (tx_valid_last),
        .tx_first      (tx_first),
        .tx_ready      (tx_ready),
        .send_token    (send_token),
        .token_pid     (token_pid),
        .send_data     (send_data),
        .data_pid      (data_pid),
        .data_len      (data_len),
        .abort         (abort),
        .tx_data_st    (tx_data_st),
        .rd_next       (rd_next),
        .busy          (busy),
        .done          (done),
        .len_err       (len_err)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] payload [0:2047];
    int         idx;
    logic [7:0] q_bytes [$];
    logic [7:0] exp_q [$];
    int n_rd, n_done, n_len_err, n_valid, stable_err, n_first, n_last, first_idx, last_idx;
    bit timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reflected-form USB CRC16; returns the complemented residue, low byte sent first.
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            r = r ^ {8'h00, payload[i]};
            for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return ~r;
    endfunction

    task automatic req_data(input logic [3:0] p, input int len);
        send_data = 1'b1;
        data_pid  = p;
        data_len  = len[CNT_W-1:0];
        tick();
        send_data = 1'b0;
    endtask

    // Plays the UTMI sink and IDMA source until done or budget expiry; records what was sent.
    task automatic run_pkt(input bit toggle, input int budget);
        logic [7:0] pb;
        bit pf, pl, held;
        q_bytes.delete();
        n_rd = 0; n_done = 0; n_len_err = 0; n_valid = 0; stable_err = 0;
        n_first = 0; n_last = 0; first_idx = -1; last_idx = -1;
        held = 0; pb = 8'h00; pf = 0; pl = 0;
        timeout = 1; idx = 0;
        for (int c = 0; c < budget; c++) begin
            tx_ready   = toggle ? (c % 2 == 0) : 1'b1;
            tx_data_st = payload[idx];
            @(negedge clk);
            if (len_err) n_len_err++;
            if (tx_valid) begin
                n_valid++;
                if (held && (tx_data !== pb || tx_first !== pf || tx_valid_last !== pl)) stable_err++;
                held = !tx_ready; pb = tx_data; pf = tx_first; pl = tx_valid_last;
                if (tx_ready) begin
                    if (tx_first)      begin n_first++; first_idx = q_bytes.size(); end
                    if (tx_valid_last) begin n_last++;  last_idx  = q_bytes.size(); end
                    q_bytes.push_back(tx_data);
                end
            end
            if (rd_next) begin n_rd++; idx++; end
            if (done) n_done++;
            tick();
            if (n_done != 0) begin timeout = 0; break; end
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_valid_last, tx_first, rd_next, busy, done, len_err, tx_data} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {tx_valid, tx_valid_last, tx_first, rd_next, busy, done, len_err, tx_data});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_token();
        tx_ready = 1'b1; send_token = 1'b1; token_pid = 4'b0010;
        tick();
        send_token = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_first, tx_valid_last, done, tx_data} !== {4'b1111, 8'hD2}) begin
            failures++;
            $display("FAIL token_ack got=%b_%h want=1111_d2", {tx_valid, tx_first, tx_valid_last, done}, tx_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({busy, tx_valid} !== 2'b00) begin
            failures++;
            $display("FAIL token_idle got=%b want=00", {busy, tx_valid});
        end
        tick();
    endtask

    task automatic test_priority();
        tx_ready = 1'b1;
        send_token = 1'b1; token_pid = 4'b1010;
        send_data = 1'b1; data_pid = 4'b0011; data_len = 11'd3;
        tick();
        send_token = 1'b0; send_data = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_valid_last, done, tx_data} !== {2'b11, 8'h5A}) begin
            failures++;
            $display("FAIL priority_token got=%b_%h want=11_5a", {tx_valid_last, done}, tx_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({busy, tx_valid} !== 2'b00) begin
            failures++;
            $display("FAIL priority_data_dropped got=%b want=00", {busy, tx_valid});
        end
        tick();
    endtask

    task automatic check_zlp(input string tag);
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL %s_timeout done never seen", tag);
        end
        checks++;
        if (q_bytes.size() != 3) begin
            failures++;
            $display("FAIL %s_len got=%0d want=3", tag, q_bytes.size());
        end else if ({q_bytes[0], q_bytes[1], q_bytes[2]} !== 24'hC30000) begin
            failures++;
            $display("FAIL %s_bytes got=%h%h%h want=c30000", tag, q_bytes[0], q_bytes[1], q_bytes[2]);
        end
        checks++;
        if ({n_first, n_last, first_idx, last_idx} !== {32'd1, 32'd1, 32'd0, 32'd2}) begin
            failures++;
            $display("FAIL %s_flags got first=%0d@%0d last=%0d@%0d want first=1@0 last=1@2", tag, n_first, first_idx, n_last, last_idx);
        end
        checks++;
        if ({n_rd, n_done, n_valid} !== {32'd0, 32'd1, 32'd3}) begin
            failures++;
            $display("FAIL %s_counts got rd=%0d done=%0d cyc=%0d want 0 1 3", tag, n_rd, n_done, n_valid);
        end
    endtask

    task automatic test_zero_len();
        req_data(4'b0011, 0);
        run_pkt(1'b0, 20);
        check_zlp("zlp");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL zlp_busy_after got=%b want=0", busy);
        end
        tick();
    endtask

    task automatic compare_stream(input string tag);
        int bad;
        bad = -1;
        checks++;
        if (q_bytes.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d want=%0d", tag, q_bytes.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (bad < 0 && q_bytes[i] !== exp_q[i]) bad = i;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s_byte[%0d] got=%h want=%h", tag, bad, q_bytes[bad], exp_q[bad]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] c;
        for (int i = 0; i < 4; i++) payload[i] = 8'(i + 1);
        c = crc_model(4);
        exp_q = '{8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, c[7:0], c[15:8]};
        req_data(4'b1011, 4);
        run_pkt(1'b1, 100);
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL stall_timeout done never seen");
        end
        compare_stream("stall");
        checks++;
        if ({n_rd, n_done} !== {32'd4, 32'd1}) begin
            failures++;
            $display("FAIL stall_counts got rd=%0d done=%0d want 4 1", n_rd, n_done);
        end
        checks++;
        if (stable_err != 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d changes want=0", stable_err);
        end
        checks++;
        if ({first_idx, last_idx, n_len_err} !== {32'd0, 32'd6, 32'd0}) begin
            failures++;
            $display("FAIL stall_flags got first@%0d last@%0d len_err=%0d want 0 6 0", first_idx, last_idx, n_len_err);
        end
    endtask

    task automatic test_oversize();
        logic [15:0] c;
        for (int i = 0; i < 2048; i++) payload[i] = 8'(i * 7 + 3);
        c = crc_model(MAX_PKT);
        exp_q.delete();
        exp_q.push_back(8'h87);
        for (int i = 0; i < MAX_PKT; i++) exp_q.push_back(payload[i]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        req_data(4'b0111, MAX_PKT + 5);
        run_pkt(1'b0, 2000);
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL oversize_timeout done never seen");
        end
        checks++;
        if (n_len_err != 1) begin
            failures++;
            $display("FAIL oversize_len_err got=%0d want=1", n_len_err);
        end
        checks++;
        if (n_rd != MAX_PKT) begin
            failures++;
            $display("FAIL oversize_rd_next got=%0d want=%0d", n_rd, MAX_PKT);
        end
        compare_stream("oversize");
        checks++;
        if (n_valid != MAX_PKT + 3) begin
            failures++;
            $display("FAIL oversize_cycles got=%0d want=%0d", n_valid, MAX_PKT + 3);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) payload[i] = 8'hA0 + 8'(i);
        req_data(4'b0011, 8);
        tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_first, tx_data} !== {2'b11, 8'hC3}) begin
            failures++;
            $display("FAIL abort_pid got=%b_%h want=11_c3", {tx_valid, tx_first}, tx_data);
        end
        tick();
        tx_data_st = payload[0];
        tick();
        tx_data_st = payload[1];
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_valid, rd_next, done, tx_data} !== {3'b100, 8'hA1}) begin
            failures++;
            $display("FAIL abort_cycle got=%b_%h want=100_a1", {tx_valid, rd_next, done}, tx_data);
        end
        tick();
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_after got=%b want=000", {tx_valid, busy, done});
        end
        tick();
        send_token = 1'b1; token_pid = 4'b1010;
        tick();
        send_token = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_first, done, tx_data} !== {3'b111, 8'h5A}) begin
            failures++;
            $display("FAIL abort_new_token got=%b_%h want=111_5a", {tx_valid, tx_first, done}, tx_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] c;
        payload[0] = 8'h11; payload[1] = 8'h22;
        c = crc_model(2);
        req_data(4'b0011, 2);
        tx_ready = 1'b1;
        tick();
        tx_data_st = payload[0];
        tick();
        tx_data_st = payload[1];
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_valid_last, tx_data} !== {2'b10, c[7:0]}) begin
            failures++;
            $display("FAIL rstmid_crc1 got=%b_%h want=10_%h", {tx_valid, tx_valid_last}, tx_data, c[7:0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_valid_last, tx_first, rd_next, busy, done, len_err, tx_data} !== 15'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h want=0", {tx_valid, tx_valid_last, tx_first, rd_next, busy, done, len_err, tx_data});
        end
        rst = 1'b1;
        tick();
        req_data(4'b0011, 0);
        run_pkt(1'b0, 20);
        check_zlp("rstmid_zlp");
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) payload[i] = 8'h00;
        test_reset();
        test_token();
        test_priority();
        test_zero_len();
        test_stall();
        test_oversize();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
